lepton_vospi_ctrl: RTL

// - Sequences the SPI master for Lepton VoSPI capture: gates the SPI enable, parses the received byte stream into
//   164-byte packets and drops discard packets. It tracks line numbers and forces a resync (enable low) on loss of sync.
// - Sits between spi_master (byte source) and the frame buffer/pixel sink; emits 16-bit pixels with line/frame markers.

---
 rtl/lepton_pkg.sv | 29 ++
 rtl/lepton_vospi_ctrl_if.sv | 30 +++
 rtl/lepton_resync_timer.sv | 26 ++
 rtl/lepton_vospi_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lepton_pkg.sv
// Shared constants and state type for the Lepton VoSPI capture controller.
package lepton_pkg;

  localparam int unsigned HDR_BYTES     = 4;
  localparam int unsigned PAYLOAD_BYTES = 160;
  localparam int unsigned PACKET_BYTES  = HDR_BYTES + PAYLOAD_BYTES;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned LINE_W = 6;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned ID_W   = 12;

  localparam logic [3:0] DISCARD_NIBBLE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESYNC,
    ST_HDR,
    ST_PAYLOAD,
    ST_SKIP
  } vospi_state_t;

  // Saturating increment for the 8-bit resync event counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/lepton_vospi_ctrl_if.sv
// Byte stream in from spi_master, control/status and pixel stream out to the sink.
interface lepton_vospi_ctrl_if;
  import lepton_pkg::*;

  logic              start;
  logic              spi_en;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic [LINE_W-1:0] pix_line;
  logic              pix_sof;
  logic              pix_eol;
  logic              frame_done;
  logic              resync;
  logic [ERR_W-1:0]  err_count;

  modport master (
    input  start, rx_byte, rx_valid,
    output spi_en, pix_data, pix_valid, pix_line, pix_sof, pix_eol,
           frame_done, resync, err_count
  );

  modport slave (
    output start, rx_byte, rx_valid,
    input  spi_en, pix_data, pix_valid, pix_line, pix_sof, pix_eol,
           frame_done, resync, err_count
  );

endinterface

// File: rtl/lepton_resync_timer.sv
// Counts the SPI-idle window that lets the sensor drop its VoSPI sync; expiry reopens spi_en.
module lepton_resync_timer #(
  parameter int unsigned RESYNC_CYCLES = 5550000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire_c = run && (cnt == CNT_W'(RESYNC_CYCLES - 1));

  // Held at zero while not running so every window starts from a full load.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (!expire_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lepton_vospi_ctrl.sv
// VoSPI capture sequencer: gates spi_en, parses 164-byte packets, emits pixels, resyncs on loss of sync.
module lepton_vospi_ctrl
  import lepton_pkg::*;
#(
  parameter int unsigned LINES         = 60,
  parameter int unsigned PIX_PER_LINE  = 80,
  parameter int unsigned RESYNC_CYCLES = 5550000,
  parameter int unsigned MAX_DISCARDS  = 2000
) (
  input logic                 clk,
  input logic                 rst,
  lepton_vospi_ctrl_if.master bus
);

  localparam int unsigned DISC_W        = $clog2(MAX_DISCARDS + 1);
  localparam int unsigned LAST_HDR      = HDR_BYTES - 1;
  localparam int unsigned LAST_BYTE     = PACKET_BYTES - 1;
  localparam int unsigned FIRST_PIX     = HDR_BYTES + 1;
  localparam int unsigned LAST_PIX_BYTE = HDR_BYTES + 2 * PIX_PER_LINE - 1;

  vospi_state_t      state, state_d;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_d;
  logic [3:0]        id_nib, id_nib_d;
  logic [BYTE_W-1:0] id_lo, id_lo_d;
  logic [BYTE_W-1:0] pix_hi, pix_hi_d;
  logic [LINE_W-1:0] expect_line, expect_line_d;
  logic [DISC_W-1:0] discard_cnt, discard_cnt_d;
  logic              done_arm, done_arm_d;

  logic              spi_en_d, pix_valid_d, pix_sof_d, pix_eol_d, frame_done_d, resync_d;
  logic [PIX_W-1:0]  pix_data_d;
  logic [LINE_W-1:0] pix_line_d;
  logic [ERR_W-1:0]  err_count_d;

  logic              timer_run_c, timer_expire_c, enter_resync_c, last_byte_c;
  logic [ID_W-1:0]   line_c;

  assign timer_run_c = (state == ST_RESYNC);
  assign line_c      = {id_nib, id_lo};
  assign last_byte_c = (byte_cnt == BYTE_W'(LAST_BYTE));

  lepton_resync_timer #(
    .RESYNC_CYCLES(RESYNC_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (timer_run_c),
    .expire_c (timer_expire_c)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d        = state;
    byte_cnt_d     = byte_cnt;
    id_nib_d       = id_nib;
    id_lo_d        = id_lo;
    pix_hi_d       = pix_hi;
    expect_line_d  = expect_line;
    discard_cnt_d  = discard_cnt;
    done_arm_d     = 1'b0;
    enter_resync_c = 1'b0;
    pix_valid_d    = 1'b0;
    pix_sof_d      = 1'b0;
    pix_eol_d      = 1'b0;
    pix_data_d     = bus.pix_data;
    pix_line_d     = bus.pix_line;
    frame_done_d   = done_arm;
    err_count_d    = bus.err_count;

    case (state)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RESYNC;
      end

      ST_RESYNC: begin
        byte_cnt_d = '0;
        if (timer_expire_c) begin
          state_d       = ST_HDR;
          expect_line_d = '0;
          discard_cnt_d = '0;
        end
      end

      ST_HDR: begin
        if (bus.rx_valid) begin
          byte_cnt_d = byte_cnt + BYTE_W'(1);
          if (byte_cnt == BYTE_W'(0)) id_nib_d = bus.rx_byte[3:0];
          if (byte_cnt == BYTE_W'(1)) id_lo_d = bus.rx_byte;
          if (byte_cnt == BYTE_W'(LAST_HDR)) begin
            if (id_nib == DISCARD_NIBBLE) begin
              state_d       = ST_SKIP;
              discard_cnt_d = discard_cnt + DISC_W'(1);
            end else if (line_c >= ID_W'(LINES)) begin
              enter_resync_c = 1'b1;
            end else if (line_c == ID_W'(expect_line)) begin
              state_d       = ST_PAYLOAD;
              discard_cnt_d = '0;
            end else if (expect_line == '0) begin
              state_d       = ST_SKIP;
              discard_cnt_d = discard_cnt + DISC_W'(1);
            end else begin
              enter_resync_c = 1'b1;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          byte_cnt_d = last_byte_c ? '0 : byte_cnt + BYTE_W'(1);
          // Payload starts at an even byte index, so odd counter values close a pixel.
          if (!byte_cnt[0]) begin
            pix_hi_d = bus.rx_byte;
          end else begin
            pix_valid_d = 1'b1;
            pix_data_d  = {pix_hi, bus.rx_byte};
            pix_line_d  = expect_line;
            pix_sof_d   = (expect_line == '0) && (byte_cnt == BYTE_W'(FIRST_PIX));
            pix_eol_d   = (byte_cnt == BYTE_W'(LAST_PIX_BYTE));
          end
          if (last_byte_c) begin
            state_d = ST_HDR;
            if (expect_line == LINE_W'(LINES - 1)) begin
              expect_line_d = '0;
              done_arm_d    = 1'b1;
            end else begin
              expect_line_d = expect_line + LINE_W'(1);
            end
          end
        end
      end

      ST_SKIP: begin
        if (bus.rx_valid) begin
          byte_cnt_d = last_byte_c ? '0 : byte_cnt + BYTE_W'(1);
          if (last_byte_c) begin
            if (discard_cnt >= DISC_W'(MAX_DISCARDS)) enter_resync_c = 1'b1;
            else state_d = ST_HDR;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_resync_c) begin
      state_d     = ST_RESYNC;
      err_count_d = sat_inc(bus.err_count);
    end

    // Dropping start abandons everything in flight.
    if (!bus.start) begin
      state_d      = ST_IDLE;
      pix_valid_d  = 1'b0;
      pix_sof_d    = 1'b0;
      pix_eol_d    = 1'b0;
      done_arm_d   = 1'b0;
      frame_done_d = 1'b0;
      err_count_d  = bus.err_count;
    end

    spi_en_d = (state_d == ST_HDR) || (state_d == ST_PAYLOAD) || (state_d == ST_SKIP);
    resync_d = (state_d == ST_RESYNC);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      byte_cnt       <= '0;
      id_nib         <= '0;
      id_lo          <= '0;
      pix_hi         <= '0;
      expect_line    <= '0;
      discard_cnt    <= '0;
      done_arm       <= 1'b0;
      bus.spi_en     <= 1'b0;
      bus.pix_data   <= '0;
      bus.pix_valid  <= 1'b0;
      bus.pix_line   <= '0;
      bus.pix_sof    <= 1'b0;
      bus.pix_eol    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.resync     <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      state          <= state_d;
      byte_cnt       <= byte_cnt_d;
      id_nib         <= id_nib_d;
      id_lo          <= id_lo_d;
      pix_hi         <= pix_hi_d;
      expect_line    <= expect_line_d;
      discard_cnt    <= discard_cnt_d;
      done_arm       <= done_arm_d;
      bus.spi_en     <= spi_en_d;
      bus.pix_data   <= pix_data_d;
      bus.pix_valid  <= pix_valid_d;
      bus.pix_line   <= pix_line_d;
      bus.pix_sof    <= pix_sof_d;
      bus.pix_eol    <= pix_eol_d;
      bus.frame_done <= frame_done_d;
      bus.resync     <= resync_d;
      bus.err_count  <= err_count_d;
    end
  end

endmodule
